// File: rtl/pointer_ctl_pkg.sv
// Shared geometry, click FSM encodings and the clamp helper for the pointer path.
package pointer_ctl_pkg;

   localparam int H_ACTIVE = 800;
   localparam int V_ACTIVE = 600;
   localparam int RECT_W = 10;
   localparam int RECT_H = 13;
   localparam int HOLD_FRAMES_DEF = 2;

   // Largest origin that keeps the whole rectangle on screen.
   localparam logic [11:0] X_MAX = 12'(H_ACTIVE - 1 - RECT_W);
   localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - 1 - RECT_H);

   // Centred rectangle shown until the first sample is committed.
   localparam logic [10:0] X_RESET = 11'((H_ACTIVE - 1 - RECT_W) / 2);
   localparam logic [10:0] Y_RESET = 11'((V_ACTIVE - 1 - RECT_H) / 2);

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } click_state_t;

   // Unsigned 12-bit clamp, then truncate to the 11-bit pointer width.
   function automatic logic [10:0] clamp(input logic [11:0] v, input logic [11:0] lim);
      logic [11:0] r;
      r = (v > lim) ? lim : v;
      return r[10:0];
   endfunction

endpackage

// File: rtl/pointer_ctl_click_debounce.sv
// Left-button debounce counted in frames; emits a press pulse on the qualifying tick.
//
//  state           | meaning
//  ----------------+-----------------------------------------------------------
//  ST_IDLE         | button released, waiting for first high sample
//  ST_PRESS_WAIT   | button high on cnt consecutive ticks, not yet qualified
//  ST_PRESSED      | click issued, waiting for release
//  ST_RELEASE_WAIT | one low sample seen; a high sample here returns to PRESSED
module click_debounce
   import pointer_ctl_pkg::*;
#(
   parameter int HOLD_FRAMES = HOLD_FRAMES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic level,
   output logic press
);

   localparam int CW = $clog2(HOLD_FRAMES + 1);

   click_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // State and frame counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and press pulse; the button is only looked at on ticks.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press   = 1'b0;
      if (tick) begin
         unique case (state_q)
            ST_IDLE: begin
               if (level) begin
                  cnt_d = CW'(1);
                  if (HOLD_FRAMES == 1) begin
                     state_d = ST_PRESSED;
                     press   = 1'b1;
                  end else begin
                     state_d = ST_PRESS_WAIT;
                  end
               end
            end
            ST_PRESS_WAIT: begin
               if (level) begin
                  cnt_d = cnt_q + CW'(1);
                  if ((cnt_q + CW'(1)) == CW'(HOLD_FRAMES)) begin
                     state_d = ST_PRESSED;
                     press   = 1'b1;
                  end
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
            ST_PRESSED: begin
               if (!level) state_d = ST_RELEASE_WAIT;
            end
            ST_RELEASE_WAIT: begin
               state_d = level ? ST_PRESSED : ST_IDLE;
               if (!level) cnt_d = '0;
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/pointer_ctl.sv
// Frame-synchronous pointer controller: clamps mouse samples, commits them at
// vblank start so the overlay never tears, and reports debounced clicks.
module pointer_ctl
   import pointer_ctl_pkg::*;
#(
   parameter int HOLD_FRAMES = HOLD_FRAMES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vblnk_in,
   input  logic [11:0] mouse_x,
   input  logic [11:0] mouse_y,
   input  logic        mouse_valid,
   input  logic        mouse_left,
   output logic [10:0] x_pointer,
   output logic [10:0] y_pointer,
   output logic        pointer_upd,
   output logic        click,
   output logic [10:0] click_x,
   output logic [10:0] click_y
);

   logic        vblnk_q;
   logic        vbl_edge;
   logic        pending;
   logic [10:0] pend_x, pend_y;
   logic        commit;
   logic        press;
   logic [10:0] new_x, new_y;

   assign vbl_edge = vblnk_in & ~vblnk_q;
   assign commit   = vbl_edge & pending;
   // Pointer value as it stands after this edge; click coordinates follow it.
   assign new_x    = commit ? pend_x : x_pointer;
   assign new_y    = commit ? pend_y : y_pointer;

   // Vblank delay; resets high so releasing reset inside vblank is not an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) vblnk_q <= 1'b1;
      else     vblnk_q <= vblnk_in;
   end

   // Sample capture; a new sample on the edge clock outlives the commit's clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= 1'b0;
         pend_x  <= '0;
         pend_y  <= '0;
      end else if (mouse_valid) begin
         pending <= 1'b1;
         pend_x  <= clamp(mouse_x, X_MAX);
         pend_y  <= clamp(mouse_y, Y_MAX);
      end else if (commit) begin
         pending <= 1'b0;
      end
   end

   // Commit pending position at vblank start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_pointer   <= X_RESET;
         y_pointer   <= Y_RESET;
         pointer_upd <= 1'b0;
      end else begin
         x_pointer   <= new_x;
         y_pointer   <= new_y;
         pointer_upd <= commit;
      end
   end

   click_debounce #(
      .HOLD_FRAMES (HOLD_FRAMES)
   ) u_click_debounce (
      .clk   (clk),
      .rst   (rst),
      .tick  (vbl_edge),
      .level (mouse_left),
      .press (press)
   );

   // Click pulse and the coordinates latched with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         click   <= 1'b0;
         click_x <= '0;
         click_y <= '0;
      end else begin
         click <= press;
         if (press) begin
            click_x <= new_x;
            click_y <= new_y;
         end
      end
   end

endmodule
